// File: rtl/arbitro_rr_demux_pkg.sv
// Shared types and helpers for the round-robin input arbiter / class demux.
package arbitro_pkg;

  localparam int NUM_Q = 4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2,
    STALL  = 2'd3
  } state_t;

  function automatic logic [NUM_Q-1:0] dest_onehot(input logic [1:0] cls);
    dest_onehot = NUM_Q'(1) << cls;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NUM_Q-1:0] oh);
    onehot_idx = 2'd0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (oh[i]) onehot_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/arbitro_rr_demux_rr_picker.sv
// Round-robin selector: first eligible queue starting at rr_ptr, wrapping mod 4.
module rr_picker
  import arbitro_pkg::*;
(
  input  logic [NUM_Q-1:0] eligible,
  input  logic [1:0]       rr_ptr,
  output logic [NUM_Q-1:0] grant,
  output logic             grant_valid
);

  logic [1:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = rr_ptr;
    for (int off = 0; off < NUM_Q; off++) begin
      idx = rr_ptr + 2'(off);
      if (!grant_valid && eligible[idx]) begin
        grant[idx]  = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_demux.sv
// Pops four input FIFOs round-robin and steers each returned word to the
// output FIFO selected by its two class bits.
module arbitro_rr_demux
  import arbitro_pkg::*;
#(
  parameter int BITNUMBER = 6,
  parameter int RD_LAT    = 2,
  parameter int HOLDOFF   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_Q-1:0]           in_empty,
  input  logic [NUM_Q*BITNUMBER-1:0] in_data,
  input  logic [NUM_Q-1:0]           in_valid,
  output logic [NUM_Q-1:0]           in_pop,
  input  logic [NUM_Q-1:0]           out_pause,
  output logic [NUM_Q-1:0]           out_push,
  output logic [BITNUMBER-1:0]       out_data,
  output logic                       active_out,
  output logic                       idle_out,
  output logic                       err_multi_valid
);

  localparam int INF_W = $clog2(RD_LAT + 2);
  localparam int HO_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  state_t                 state, next_state;
  logic [1:0]             rr_ptr;
  logic [INF_W-1:0]       inflight;
  logic [HO_W-1:0]        holdoff_cnt [NUM_Q];
  logic [NUM_Q-1:0]       eligible;
  logic [NUM_Q-1:0]       holdoff_act;
  logic [NUM_Q-1:0]       grant;
  logic                   grant_valid;
  logic                   grant_fire;
  logic                   drain_done;
  logic                   fwd_vld_p0;
  logic                   fwd_multi_p0;
  logic [BITNUMBER-1:0]   fwd_word_p0;
  logic                   active_nxt;
  logic                   idle_nxt;

  // Words already requested always come back, so the count saturates at zero
  // instead of wrapping if a stray in_valid ever arrives.
  function automatic logic [INF_W-1:0] inflight_upd(input logic [INF_W-1:0] cur,
                                                     input logic inc,
                                                     input logic dec);
    case ({inc, dec})
      2'b10:   inflight_upd = cur + 1'b1;
      2'b01:   inflight_upd = (cur == '0) ? cur : cur - 1'b1;
      default: inflight_upd = cur;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      holdoff_act[i] = (holdoff_cnt[i] != '0);
      eligible[i]    = !in_empty[i] && !holdoff_act[i];
    end
  end

  rr_picker u_rr_picker (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign grant_fire = (state == ACTIVE) && (out_pause == '0) && grant_valid;

  // Lowest-index in_valid wins when upstream misbehaves and several fire.
  always_comb begin
    fwd_vld_p0   = |in_valid;
    fwd_multi_p0 = (in_valid & (in_valid - 1'b1)) != '0;
    fwd_word_p0  = '0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (in_valid[i]) fwd_word_p0 = in_data[i*BITNUMBER +: BITNUMBER];
    end
  end

  assign drain_done = (&in_empty) && (inflight == '0) && !fwd_vld_p0 &&
                      (holdoff_act == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:   next_state = IDLE;
      IDLE:   if ((|eligible) && (out_pause == '0)) next_state = ACTIVE;
      ACTIVE: begin
        if (|out_pause)      next_state = STALL;
        else if (drain_done) next_state = IDLE;
      end
      STALL: begin
        if ((out_pause == '0) && (|eligible)) next_state = ACTIVE;
        else if (drain_done)                  next_state = IDLE;
      end
      default: next_state = INIT;
    endcase
  end

  always_comb begin
    active_nxt = (next_state == ACTIVE);
    idle_nxt   = (next_state == IDLE);
  end

  // Stage p0 -> registered outputs: pop request, arbitration state, forwarded word.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_pop          <= '0;
      out_push        <= '0;
      out_data        <= '0;
      active_out      <= 1'b0;
      idle_out        <= 1'b0;
      err_multi_valid <= 1'b0;
      rr_ptr          <= 2'd0;
      inflight        <= '0;
      for (int i = 0; i < NUM_Q; i++) holdoff_cnt[i] <= '0;
    end else begin
      in_pop     <= grant_fire ? grant : '0;
      active_out <= active_nxt;
      idle_out   <= idle_nxt;
      if (grant_fire) rr_ptr <= onehot_idx(grant) + 2'd1;
      for (int i = 0; i < NUM_Q; i++) begin
        if (grant_fire && grant[i])  holdoff_cnt[i] <= HO_W'(HOLDOFF);
        else if (holdoff_act[i])     holdoff_cnt[i] <= holdoff_cnt[i] - 1'b1;
      end
      inflight <= inflight_upd(inflight, grant_fire, fwd_vld_p0);
      out_push <= fwd_vld_p0 ? dest_onehot(fwd_word_p0[BITNUMBER-1 -: 2]) : '0;
      if (fwd_vld_p0) out_data <= fwd_word_p0;
      err_multi_valid <= err_multi_valid | fwd_multi_p0;
    end
  end

endmodule

// File: tb/tb_arbitro_rr_demux.sv
// Directed bench for arbitro_rr_demux with a small upstream FIFO model.
module tb_arbitro_rr_demux;

  localparam int BN = 6;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    in_empty;
  logic [4*BN-1:0] in_data;
  logic [3:0]    in_valid;
  logic [3:0]    in_pop;
  logic [3:0]    out_pause;
  logic [3:0]    out_push;
  logic [BN-1:0] out_data;
  logic          active_out;
  logic          idle_out;
  logic          err_multi_valid;

  always #5 clk = ~clk;

  arbitro_rr_demux #(.BITNUMBER(BN), .RD_LAT(RL), .HOLDOFF(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_pop          (in_pop),
    .out_pause       (out_pause),
    .out_push        (out_push),
    .out_data        (out_data),
    .active_out      (active_out),
    .idle_out        (idle_out),
    .err_multi_valid (err_multi_valid)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt [4];
  logic [5:0]  word [4];
  logic [3:0]  pipe [RL];
  bit          auto_m;

  typedef struct {
    logic [3:0] vld;
    logic [5:0] w;
    logic [3:0] e_push;
    logic [5:0] e_data;
  } fwd_vec_t;

  fwd_vec_t    tv [5];
  logic [3:0]  rr_exp [9];
  logic [3:0]  ho_exp [6];
  logic [3:0]  ws_pop [6];
  logic [3:0]  ws_push [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_env();
    for (int i = 0; i < 4; i++) begin
      in_empty[i]          = (cnt[i] == 0);
      in_data[i*BN +: BN]  = word[i];
    end
  endtask

  // One clock: the upstream model sees the pop that was high during the cycle
  // just ended and returns its word RD_LAT cycles after the pop.
  task automatic tick();
    logic [3:0] p;
    p = in_pop;
    @(posedge clk);
    #1;
    if (auto_m) begin
      for (int k = RL - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = p;
      for (int i = 0; i < 4; i++) if (p[i] && cnt[i] > 0) cnt[i]--;
      in_valid = pipe[RL-1];
    end
    drive_env();
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_pop != 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok, output logic [3:0] prev);
    ok   = 1'b0;
    prev = out_push;
    for (int i = 0; i < 30; i++) begin
      if (idle_out) begin
        ok = 1'b1;
        break;
      end
      prev = out_push;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    logic [3:0] prev;

    tv[0] = '{4'b0001, 6'b00_0011, 4'b0001, 6'b00_0011};
    tv[1] = '{4'b0010, 6'b01_1110, 4'b0010, 6'b01_1110};
    tv[2] = '{4'b0100, 6'b11_0001, 4'b1000, 6'b11_0001};
    tv[3] = '{4'b1000, 6'b10_1010, 4'b0100, 6'b10_1010};
    tv[4] = '{4'b0000, 6'b01_1111, 4'b0000, 6'b10_1010};
    rr_exp  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    ho_exp  = '{4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0};
    ws_pop  = '{4'h8, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0};
    ws_push = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h8, 4'h2};

    reset     = 1'b1;
    out_pause = 4'b0;
    in_valid  = 4'b0;
    auto_m    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      word[i] = 6'b0;
    end
    for (int k = 0; k < RL; k++) pipe[k] = 4'b0;
    drive_env();

    // Reset held two cycles
    tick();
    tick();
    chk("rst_in_pop", 32'(in_pop), 0);
    chk("rst_out_push", 32'(out_push), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_active", 32'(active_out), 0);
    chk("rst_idle", 32'(idle_out), 0);
    chk("rst_err", 32'(err_multi_valid), 0);
    reset = 1'b0;
    chk("init_idle_low", 32'(idle_out), 0);
    tick();
    chk("idle_after_init", 32'(idle_out), 1);
    chk("active_after_init", 32'(active_out), 0);
    repeat (3) begin
      tick();
      chk("no_pop_idle", 32'(in_pop), 0);
    end

    // Forwarding table, driven by hand
    auto_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int q = 0; q < 4; q++) word[q] = tv[i].vld[q] ? tv[i].w : 6'b01_0101;
      drive_env();
      in_valid = tv[i].vld;
      tick();
      in_valid = 4'b0;
      chk($sformatf("fwd_push_%0d", i), 32'(out_push), 32'(tv[i].e_push));
      chk($sformatf("fwd_data_%0d", i), 32'(out_data), 32'(tv[i].e_data));
    end
    chk("fwd_err_clear", 32'(err_multi_valid), 0);
    chk("fwd_still_idle", 32'(idle_out), 1);
    tick();
    auto_m = 1'b1;

    // Single queue: holdoff spaces its pops every other cycle
    word[1] = 6'b00_0001;
    cnt[1]  = 3;
    drive_env();
    wait_pop(ok);
    chk("ho_pop_seen", 32'(ok), 1);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("ho_pop_%0d", j), 32'(in_pop), 32'(ho_exp[j]));
      tick();
    end
    wait_idle(ok, prev);
    chk("ho_idle", 32'(ok), 1);

    // Wrap and skip: rr_ptr now 2, only q3 and q1 hold data
    word[3] = 6'b01_0011;
    word[1] = 6'b11_0010;
    cnt[3]  = 2;
    cnt[1]  = 1;
    drive_env();
    wait_pop(ok);
    chk("ws_pop_seen", 32'(ok), 1);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("ws_pop_%0d", j), 32'(in_pop), 32'(ws_pop[j]));
      chk($sformatf("ws_push_%0d", j), 32'(out_push), 32'(ws_push[j]));
      if (j == 4) chk("ws_data_q1", 32'(out_data), 32'h32);
      tick();
    end
    wait_idle(ok, prev);
    chk("ws_idle", 32'(ok), 1);

    // Full round robin, then drain
    for (int i = 0; i < 4; i++) begin
      word[i] = 6'b10_0101;
      cnt[i]  = 10;
    end
    drive_env();
    wait_pop(ok);
    chk("rr_pop_seen", 32'(ok), 1);
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("rr_pop_%0d", j), 32'(in_pop), 32'(rr_exp[j]));
      chk($sformatf("rr_push_%0d", j), 32'(out_push), (j < 3) ? 32'h0 : 32'h4);
      if (j >= 3) chk($sformatf("rr_data_%0d", j), 32'(out_data), 32'h25);
      if (j < 8) tick();
    end
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_env();
    wait_idle(ok, prev);
    chk("drain_idle", 32'(ok), 1);
    chk("drain_last_push", 32'(prev), 32'h4);
    chk("drain_push_low", 32'(out_push), 0);

    // Pause mid-burst: rr_ptr is 1 after the round-robin run
    for (int i = 0; i < 4; i++) cnt[i] = 10;
    drive_env();
    wait_pop(ok);
    chk("ps_pop_seen", 32'(ok), 1);
    chk("ps_first_pop", 32'(in_pop), 32'h2);
    out_pause = 4'b0010;
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk($sformatf("ps_nopop_%0d", j), 32'(in_pop), 0);
      chk($sformatf("ps_push_%0d", j), 32'(out_push), (j == 3) ? 32'h4 : 32'h0);
      if (j == 1) begin
        chk("ps_stall_active", 32'(active_out), 0);
        chk("ps_stall_idle", 32'(idle_out), 0);
      end
    end
    out_pause = 4'b0;
    tick();
    chk("ps_resume_active", 32'(active_out), 1);
    chk("ps_resume_nopop", 32'(in_pop), 0);
    tick();
    chk("ps_resume_pop", 32'(in_pop), 32'h4);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_env();
    wait_idle(ok, prev);
    chk("ps_idle", 32'(ok), 1);

    // Two in_valid in one cycle
    auto_m  = 1'b0;
    word[1] = 6'b00_1100;
    word[2] = 6'b11_0011;
    drive_env();
    in_valid = 4'b0110;
    tick();
    in_valid = 4'b0;
    chk("mv_push", 32'(out_push), 32'h1);
    chk("mv_data", 32'(out_data), 32'h0c);
    chk("mv_err_set", 32'(err_multi_valid), 1);
    repeat (3) tick();
    chk("mv_err_sticky", 32'(err_multi_valid), 1);

    // Reset clears the sticky error
    reset = 1'b1;
    tick();
    chk("rst2_err", 32'(err_multi_valid), 0);
    chk("rst2_idle", 32'(idle_out), 0);
    chk("rst2_push", 32'(out_push), 0);
    reset = 1'b0;
    tick();
    tick();
    chk("rst2_idle_back", 32'(idle_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
